// File: rtl/or1200_cl_pad_gen_if.sv
// ----------------------------------------------------------------------------
// or1200_cl_pad_gen_if
//   Bundles the request/response signals of the cache-line pad generator.
//   The request side (secure_exec, req, seed_in, key_in, invalidate) and the
//   pad results (busy, done, pad_hit, pads_out) face the D-cache line-fill
//   control. The eng_* signals face the AES engine wrappers.
//   Modports:
//     slave  - pad generator view (drives results and engine loads)
//     master - line-fill / engine side view
// ----------------------------------------------------------------------------
interface or1200_cl_pad_gen_if #(
   parameter int NUM_PADS = 4,
   parameter int NUM_ENG  = 2,
   parameter int SEED_W   = 64
);
   logic                      secure_exec;
   logic                      req;
   logic [SEED_W-1:0]         seed_in;
   logic [127:0]              key_in;
   logic                      invalidate;
   logic                      busy;
   logic                      done;
   logic                      pad_hit;
   logic [NUM_PADS*128-1:0]   pads_out;
   logic [NUM_ENG-1:0]        eng_ld;
   logic [NUM_ENG*128-1:0]    eng_text;
   logic [127:0]              eng_key;
   logic [NUM_ENG-1:0]        eng_done;
   logic [NUM_ENG*128-1:0]    eng_pad;

   modport slave (
      input  secure_exec, req, seed_in, key_in, invalidate, eng_done, eng_pad,
      output busy, done, pad_hit, pads_out, eng_ld, eng_text, eng_key
   );

   modport master (
      output secure_exec, req, seed_in, key_in, invalidate, eng_done, eng_pad,
      input  busy, done, pad_hit, pads_out, eng_ld, eng_text, eng_key
   );
endinterface

// File: rtl/or1200_cl_pad_gen.sv
// ----------------------------------------------------------------------------
// or1200_cl_pad_gen
//   Generates NUM_PADS counter-mode pads for one cache line by running
//   NUM_ENG external AES engines over NUM_PADS/NUM_ENG rounds. Engine e in
//   round r encrypts {zeros, seed, r*NUM_ENG+e}. The last completed seed/key
//   pair is remembered so an immediate repeat reuses the stored pads.
//   Ports:
//     clk, rst  - core clock, asynchronous active-high reset
//     bus       - slave modport: request/result signals toward line-fill
//                 control and load/result signals toward the AES engines
// ----------------------------------------------------------------------------
module or1200_cl_pad_gen #(
   parameter int NUM_PADS = 4,
   parameter int NUM_ENG  = 2,
   parameter int SEED_W   = 64
) (
   input logic                clk,
   input logic                rst,
   or1200_cl_pad_gen_if.slave bus
);
   localparam int IDX_W  = $clog2(NUM_PADS);
   localparam int ROUNDS = NUM_PADS / NUM_ENG;
   localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);
   localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]              state;
   logic [RND_W-1:0]        round;
   logic [NUM_ENG-1:0]      done_mask;
   logic [NUM_ENG-1:0]      mask_next;
   logic                    hit_flag;
   logic                    tag_valid;
   logic [SEED_W-1:0]       seed_q;
   logic [SEED_W-1:0]       tag_seed;
   logic [127:0]            key_q;
   logic [127:0]            tag_key;
   logic [NUM_PADS*128-1:0] pads_q;
   logic [NUM_ENG*128-1:0]  text_q;
   logic                    accept;
   logic                    hit;
   logic                    abort;
   logic                    round_done;

   // Plaintext blocks for every engine of one round.
   function automatic logic [NUM_ENG*128-1:0] make_texts(
      input logic [SEED_W-1:0] seed,
      input logic [RND_W-1:0]  rnd
   );
      logic [NUM_ENG*128-1:0] t;
      logic [IDX_W-1:0]       idx;
      t = '0;
      for (int e = 0; e < NUM_ENG; e++) begin
         idx = IDX_W'(int'(rnd) * NUM_ENG + e);
         t[128*e + IDX_W +: SEED_W] = seed;
         t[128*e +: IDX_W]          = idx;
      end
      return t;
   endfunction

   assign accept     = (state == S_IDLE) & bus.req & bus.secure_exec;
   assign hit        = tag_valid & (bus.seed_in == tag_seed) &
                       (bus.key_in == tag_key) & ~bus.invalidate;
   assign abort      = ((state == S_LOAD) | (state == S_WAIT)) & ~bus.secure_exec;
   // Same-cycle results count toward completing the round.
   assign mask_next  = done_mask | bus.eng_done;
   assign round_done = (state == S_WAIT) & (&mask_next);

   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_DONE);
   assign bus.pad_hit  = (state == S_DONE) & hit_flag;
   assign bus.eng_ld   = {NUM_ENG{state == S_LOAD}};
   assign bus.eng_text = text_q;
   assign bus.eng_key  = key_q;
   assign bus.pads_out = pads_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         round     <= '0;
         done_mask <= '0;
         hit_flag  <= 1'b0;
         tag_valid <= 1'b0;
         seed_q    <= '0;
         tag_seed  <= '0;
         key_q     <= '0;
         tag_key   <= '0;
         pads_q    <= '0;
         text_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (hit) begin
                     hit_flag <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     hit_flag <= 1'b0;
                     seed_q   <= bus.seed_in;
                     key_q    <= bus.key_in;
                     text_q   <= make_texts(bus.seed_in, '0);
                     round    <= '0;
                     state    <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               done_mask <= '0;
               state     <= abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
               // Only the first result per engine per round is kept.
               for (int e = 0; e < NUM_ENG; e++) begin
                  if (bus.eng_done[e] & ~done_mask[e]) begin
                     pads_q[128*(int'(round)*NUM_ENG + e) +: 128] <= bus.eng_pad[128*e +: 128];
                  end
               end
               done_mask <= mask_next;
               if (abort) begin
                  state <= S_IDLE;
               end else if (round_done) begin
                  if (round == LAST_RND) begin
                     state <= S_DONE;
                  end else begin
                     round  <= round + RND_ONE;
                     text_q <= make_texts(seed_q, round + RND_ONE);
                     state  <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               if (!hit_flag) begin
                  tag_valid <= 1'b1;
                  tag_seed  <= seed_q;
                  tag_key   <= key_q;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // Later assignments override the DONE tag write.
         if (abort) tag_valid <= 1'b0;
         if (bus.invalidate) tag_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_or1200_cl_pad_gen.sv
module tb_or1200_cl_pad_gen;
   localparam int NP = 4;
   localparam int NE = 2;
   localparam int SW = 64;
   localparam int IW = 2;
   localparam int R  = NP / NE;

   typedef struct {
      bit                   hit;
      logic [NP*128-1:0]    pads;
      int                   lat;
      int                   loads;
      int                   acc_cyc;
      int                   ld_base;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   ld_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];

   // reference state: what the generator should remember
   bit                m_tv = 1'b0;
   logic [SW-1:0]     m_seed = '0;
   logic [127:0]      m_key = '0;
   logic [NP*128-1:0] m_pads = '0;

   // engine behaviour knobs and private engine state
   int           eng_lat[NE];
   bit           eng_dup[NE];
   int           eng_cnt[NE];
   bit           eng_dupl[NE];
   logic [127:0] eng_res[NE];

   or1200_cl_pad_gen_if #(.NUM_PADS(NP), .NUM_ENG(NE), .SEED_W(SW)) bus ();
   or1200_cl_pad_gen #(.NUM_PADS(NP), .NUM_ENG(NE), .SEED_W(SW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [NP*128-1:0] act,
                        input logic [NP*128-1:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
      end
   endtask

   // Pad i of a line is AES(key, {zeros, seed, i}); the bench engine's
   // cipher is a plain XOR with the key.
   function automatic logic [NP*128-1:0] model_pads(input logic [SW-1:0] s,
                                                    input logic [127:0] k);
      logic [NP*128-1:0] p;
      logic [127:0]      t;
      for (int i = 0; i < NP; i++) begin
         t = ({64'b0, s} << IW) | 128'(i);
         p[128*i +: 128] = t ^ k;
      end
      return p;
   endfunction

   // Engine model: result eng_lat cycles after the load cycle, optional
   // duplicate pulse with corrupted data one cycle later.
   initial begin
      bus.eng_done = '0;
      bus.eng_pad  = '0;
      for (int e = 0; e < NE; e++) begin
         eng_cnt[e] = 0; eng_dupl[e] = 1'b0; eng_res[e] = '0;
      end
      forever begin
         @(negedge clk);
         for (int e = 0; e < NE; e++) begin
            bus.eng_done[e] = 1'b0;
            if (bus.eng_ld[e]) begin
               eng_res[e]  = bus.eng_text[128*e +: 128] ^ bus.eng_key;
               eng_cnt[e]  = eng_lat[e];
               eng_dupl[e] = eng_dup[e];
            end else if (eng_cnt[e] > 0) begin
               eng_cnt[e]--;
               if (eng_cnt[e] == 0) begin
                  bus.eng_done[e] = 1'b1;
                  bus.eng_pad[128*e +: 128] = eng_res[e];
               end
            end else if (eng_dupl[e]) begin
               eng_dupl[e] = 1'b0;
               bus.eng_done[e] = 1'b1;
               bus.eng_pad[128*e +: 128] = ~eng_res[e];
            end
         end
      end
   end

   // Monitor: counts engine load cycles, checks every done against the queue.
   initial begin
      exp_t ex;
      forever begin
         @(negedge clk);
         if (bus.eng_ld != '0) ld_cnt++;
         if (bus.done) begin
            if (sbq.size() == 0) begin
               check("unexpected_done", bus.done, 0);
            end else begin
               ex = sbq.pop_front();
               check("pad_hit", bus.pad_hit, ex.hit);
               check("pads_out", bus.pads_out, ex.pads);
               check("latency", cyc - ex.acc_cyc + 1, ex.lat);
               check("eng_loads", ld_cnt - ex.ld_base, ex.loads);
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) check("idle_timeout", bus.busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic set_eng(input int l0, input int l1, input bit d0, input bit d1);
      eng_lat[0] = l0; eng_lat[1] = l1;
      eng_dup[0] = d0; eng_dup[1] = d1;
   endtask

   // abort_at: 0 none, >0 relative cycle in which secure_exec drops, <0 random
   task automatic run_txn(input logic [SW-1:0] seed, input logic [127:0] key,
                          input bit inv_req, input int abort_at,
                          input bit inv_done, input bit busy_req);
      exp_t ex;
      bit   hit;
      int   maxl;
      int   lat;
      int   d;
      @(negedge clk);
      bus.seed_in    = seed;
      bus.key_in     = key;
      bus.invalidate = inv_req;
      bus.req        = 1'b1;
      hit = m_tv && seed == m_seed && key == m_key && !inv_req;
      if (inv_req) m_tv = 1'b0;
      maxl = 0;
      for (int e = 0; e < NE; e++) if (eng_lat[e] > maxl) maxl = eng_lat[e];
      lat = hit ? 1 : R * (1 + maxl) + 1;
      d = abort_at;
      if (hit) d = 0;
      else if (d < 0) d = $urandom_range(1, lat - 1);
      @(posedge clk); #1;
      bus.req        = 1'b0;
      bus.invalidate = 1'b0;
      if (d == 0) begin
         ex.hit     = hit;
         ex.pads    = hit ? m_pads : model_pads(seed, key);
         ex.lat     = lat;
         ex.loads   = hit ? 0 : R;
         ex.acc_cyc = cyc;
         ex.ld_base = ld_cnt;
         sbq.push_back(ex);
         if (!hit) begin
            m_pads = ex.pads; m_seed = seed; m_key = key; m_tv = 1'b1;
         end
      end
      if (busy_req) begin
         bus.seed_in = ~seed;
         bus.req     = 1'b1;
         @(posedge clk); #1;
         bus.req     = 1'b0;
      end
      if (d > 0) begin
         for (int k = 1; k < d; k++) begin @(posedge clk); #1; end
         bus.secure_exec = 1'b0;
         @(posedge clk); #1;
         check("abort_busy", bus.busy, 0);
         check("abort_no_done", bus.done, 0);
         bus.secure_exec = 1'b1;
         m_tv = 1'b0;
         repeat (8) @(negedge clk);
      end else if (inv_done) begin
         for (int k = 1; k < lat; k++) begin @(posedge clk); #1; end
         bus.invalidate = 1'b1;
         @(posedge clk); #1;
         bus.invalidate = 1'b0;
         m_tv = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [SW-1:0]  seeds[3];
      logic [127:0]   keys[2];
      logic [SW-1:0]  s;
      logic [127:0]   k;
      int             ab;
      rst = 1'b1;
      bus.secure_exec = 1'b1;
      bus.req = 1'b0;
      bus.seed_in = '0;
      bus.key_in = '0;
      bus.invalidate = 1'b0;
      set_eng(3, 3, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_pad_hit", bus.pad_hit, 0);
      check("rst_eng_ld", bus.eng_ld, 0);
      check("rst_pads_out", bus.pads_out, 0);
      check("rst_eng_text", bus.eng_text, 0);
      check("rst_eng_key", bus.eng_key, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic miss then immediate reuse
      run_txn(64'h0123_4567_89AB_CDEF, 128'h1, 0, 0, 0, 0);
      run_txn(64'h0123_4567_89AB_CDEF, 128'h1, 0, 0, 0, 0);
      // out-of-order engines with a duplicate, corrupted pulse from engine 1
      set_eng(3, 1, 1'b0, 1'b1);
      run_txn(64'hFEDC_BA98_7654_3210, 128'h5555, 0, 0, 0, 0);
      // abort in round-1 WAIT, then same seed must miss
      set_eng(3, 3, 1'b0, 1'b0);
      run_txn(64'h1111_2222_3333_4444, 128'h77, 0, 7, 0, 0);
      run_txn(64'h1111_2222_3333_4444, 128'h77, 0, 0, 0, 0);
      // abort coinciding with the final capture; abort in LOAD
      run_txn(64'h2222, 128'h99, 0, 8, 0, 0);
      run_txn(64'h2222, 128'h99, 0, 1, 0, 0);
      // invalidate in DONE, then same seed must miss
      run_txn(64'hABCD, 128'h3, 0, 0, 1, 0);
      run_txn(64'hABCD, 128'h3, 0, 0, 0, 0);
      // invalidate alongside a would-be hit request
      run_txn(64'hABCD, 128'h3, 1, 0, 0, 0);
      // req while busy is dropped
      run_txn(64'h5A5A, 128'hC3, 0, 0, 0, 1);
      // req without secure mode is not accepted
      @(negedge clk);
      bus.secure_exec = 1'b0;
      bus.req = 1'b1;
      bus.seed_in = 64'h5A5A;
      bus.key_in = 128'hC3;
      @(posedge clk); #1;
      check("no_secure_busy", bus.busy, 0);
      bus.req = 1'b0;
      bus.secure_exec = 1'b1;

      // asynchronous reset in the middle of WAIT
      @(negedge clk);
      bus.seed_in = 64'h0BAD;
      bus.key_in = 128'h42;
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_eng_ld", bus.eng_ld, 0);
      check("arst_pads_out", bus.pads_out, 0);
      check("arst_eng_text", bus.eng_text, 0);
      check("arst_eng_key", bus.eng_key, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_tv = 1'b0;
      m_pads = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_idle", bus.busy, 0);
      end
      run_txn(64'h0123_4567_89AB_CDEF, 128'h1, 0, 0, 0, 0);

      // randomized traffic
      seeds[0] = {$urandom, $urandom};
      seeds[1] = {$urandom, $urandom};
      seeds[2] = {$urandom, $urandom};
      keys[0]  = {$urandom, $urandom, $urandom, $urandom};
      keys[1]  = {$urandom, $urandom, $urandom, $urandom};
      for (int n = 0; n < 40; n++) begin
         s = seeds[$urandom_range(0, 2)];
         k = keys[$urandom_range(0, 1)];
         if ($urandom_range(0, 2) == 0) begin s = m_seed; k = m_key; end
         set_eng($urandom_range(1, 4), $urandom_range(1, 4),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         ab = ($urandom_range(0, 5) == 0) ? -1 : 0;
         run_txn(s, k, 1'($urandom_range(0, 7) == 0), ab,
                 1'($urandom_range(0, 7) == 0),
                 1'(ab == 0 && $urandom_range(0, 7) == 0));
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
